// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: MIPS opcode/funct encodings and the ALU op-class enum shared by decoder, GPR write-enable and branch logic
package mips_alu_pkg;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR = 6'h08, FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a, FN_SLTU = 6'h2b;
  typedef enum logic [4:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV, ALU_SRAV,
    ALU_ADDI, ALU_SLTI, ALU_SLTIU, ALU_ANDI, ALU_ORI, ALU_XORI, ALU_LUI
  } alu_op_t;
endpackage

// File: rtl/mips_alu_if.sv
// mips_alu_if: EX-stage bundle (ID/EX opcode+funct, operands rrs/rrt_in, imm, shamt_in) in, registered rslt out
interface mips_alu_if;
  logic [5:0] opcode_fwd, funct_fwd, opcode, funct;
  logic [31:0] rrs, rrt_in;
  logic [15:0] imm;
  logic [4:0] shamt_in;
  logic [31:0] rslt;
  modport master (output opcode_fwd, funct_fwd, opcode, funct, rrs, rrt_in, imm, shamt_in, input rslt);
  modport slave (input opcode_fwd, funct_fwd, opcode, funct, rrs, rrt_in, imm, shamt_in, output rslt);
endinterface

// File: rtl/mips_alu_decode.sv
// mips_alu_decode: combinational {opcode, funct} -> op-class; unlisted encodings, branches, jumps -> NOP
module mips_alu_decode
  import mips_alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alu_op_t    op
);
  alu_op_t r_op;
  always_comb begin
    r_op = ALU_NOP;
    case (funct)
      FN_ADD, FN_ADDU: r_op = ALU_ADD;
      FN_SUB, FN_SUBU: r_op = ALU_SUB;
      FN_AND:  r_op = ALU_AND;
      FN_OR:   r_op = ALU_OR;
      FN_XOR:  r_op = ALU_XOR;
      FN_NOR:  r_op = ALU_NOR;
      FN_SLT:  r_op = ALU_SLT;
      FN_SLTU: r_op = ALU_SLTU;
      FN_SLL:  r_op = ALU_SLL;
      FN_SRL:  r_op = ALU_SRL;
      FN_SRA:  r_op = ALU_SRA;
      FN_SLLV: r_op = ALU_SLLV;
      FN_SRLV: r_op = ALU_SRLV;
      FN_SRAV: r_op = ALU_SRAV;
      default: r_op = ALU_NOP;
    endcase
  end
  always_comb begin
    op = ALU_NOP;
    case (opcode)
      OP_R:               op = r_op;
      OP_ADDI, OP_ADDIU,
      OP_LW, OP_SW:       op = ALU_ADDI;
      OP_SLTI:            op = ALU_SLTI;
      OP_SLTIU:           op = ALU_SLTIU;
      OP_ANDI:            op = ALU_ANDI;
      OP_ORI:             op = ALU_ORI;
      OP_XORI:            op = ALU_XORI;
      OP_LUI:             op = ALU_LUI;
      default:            op = ALU_NOP;
    endcase
  end
endmodule

// File: rtl/mips_alu.sv
// mips_alu: registered 32-bit EX-stage ALU; clk, rst (sync active-low), bus.slave carries ID/EX fields, operands and rslt
module mips_alu
  import mips_alu_pkg::*;
(
  input logic   clk,
  input logic   rst,
  mips_alu_if.slave bus
);
  alu_op_t op_nx, op;
  logic [31:0] a, b, se, ze, r, rslt_q;
  logic [4:0] vsh;
  assign a = bus.rrs;
  assign b = bus.rrt_in;
  assign se = {{16{bus.imm[15]}}, bus.imm};
  assign ze = {16'h0, bus.imm};
  assign vsh = a[4:0];
  mips_alu_decode u_dec (.opcode(bus.opcode_fwd), .funct(bus.funct_fwd), .op(op_nx));
  always_comb begin
    r = '0;
    case (op)
      ALU_ADD:   r = a + b;
      ALU_SUB:   r = a - b;
      ALU_AND:   r = a & b;
      ALU_OR:    r = a | b;
      ALU_XOR:   r = a ^ b;
      ALU_NOR:   r = ~(a | b);
      ALU_SLT:   r = {31'h0, $signed(a) < $signed(b)};
      ALU_SLTU:  r = {31'h0, a < b};
      ALU_SLL:   r = b << bus.shamt_in;
      ALU_SRL:   r = b >> bus.shamt_in;
      ALU_SRA:   r = $unsigned($signed(b) >>> bus.shamt_in);
      ALU_SLLV:  r = b << vsh;
      ALU_SRLV:  r = b >> vsh;
      ALU_SRAV:  r = $unsigned($signed(b) >>> vsh);
      ALU_ADDI:  r = a + se;
      ALU_SLTI:  r = {31'h0, $signed(a) < $signed(se)};
      ALU_SLTIU: r = {31'h0, a < se};
      ALU_ANDI:  r = a & ze;
      ALU_ORI:   r = a | ze;
      ALU_XORI:  r = a ^ ze;
      ALU_LUI:   r = {bus.imm, 16'h0};
      default:   r = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      op <= ALU_NOP;
      rslt_q <= '0;
    end else begin
      op <= op_nx;
      rslt_q <= r;
    end
  end
  assign bus.rslt = rslt_q;
endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu: table vectors, reset/feedback sequences and random instructions against a reference model
module tb_mips_alu;
  typedef struct {
    string name;
    logic [5:0] op, fn;
    logic [31:0] a, b;
    logic [15:0] imm;
    logic [4:0] sh;
    logic [31:0] exp;
  } vec_t;
  logic clk = 0, rst = 0;
  int tests = 0, fails = 0;
  mips_alu_if bus ();
  mips_alu dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  function automatic vec_t mk(string n, logic [5:0] op, logic [5:0] fn, logic [31:0] a, logic [31:0] b,
                              logic [15:0] imm, logic [4:0] sh, logic [31:0] exp);
    vec_t v;
    v.name = n; v.op = op; v.fn = fn; v.a = a; v.b = b; v.imm = imm; v.sh = sh; v.exp = exp;
    return v;
  endfunction
  function automatic logic [31:0] model(vec_t v);
    logic [31:0] se, ze, t;
    int n;
    se = {{16{v.imm[15]}}, v.imm};
    ze = {16'h0, v.imm};
    n = (v.fn == 6'h04 || v.fn == 6'h06 || v.fn == 6'h07) ? int'(v.a[4:0]) : int'(v.sh);
    if (v.op == 6'h00) begin
      case (v.fn)
        6'h20, 6'h21: return v.a + v.b;
        6'h22, 6'h23: return v.a - v.b;
        6'h24: return v.a & v.b;
        6'h25: return v.a | v.b;
        6'h26: return v.a ^ v.b;
        6'h27: return ~(v.a | v.b);
        6'h2a: return (longint'($signed(v.a)) < longint'($signed(v.b))) ? 1 : 0;
        6'h2b: return (longint'(v.a) < longint'(v.b)) ? 1 : 0;
        6'h00, 6'h04: return v.b * (32'd1 << n);
        6'h02, 6'h06: return v.b / (32'd1 << n);
        6'h03, 6'h07: begin
          t = v.b;
          for (int k = 0; k < n; k++) t = {t[31], t[31:1]};
          return t;
        end
        default: return 0;
      endcase
    end
    case (v.op)
      6'h08, 6'h09, 6'h23, 6'h2b: return v.a + se;
      6'h0a: return (longint'($signed(v.a)) < longint'($signed(se))) ? 1 : 0;
      6'h0b: return (longint'(v.a) < longint'(se)) ? 1 : 0;
      6'h0c: return v.a & ze;
      6'h0d: return v.a | ze;
      6'h0e: return v.a ^ ze;
      6'h0f: return {v.imm, 16'h0};
      default: return 0;
    endcase
  endfunction
  task automatic drive(input vec_t ex, input vec_t nx);
    bus.opcode = ex.op; bus.funct = ex.fn; bus.rrs = ex.a; bus.rrt_in = ex.b;
    bus.imm = ex.imm; bus.shamt_in = ex.sh;
    bus.opcode_fwd = nx.op; bus.funct_fwd = nx.fn;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] exp);
    tests++;
    if (bus.rslt !== exp) begin
      fails++;
      $display("FAIL %s: rslt=%h expected=%h", name, bus.rslt, exp);
    end
  endtask
  vec_t tab[$];
  vec_t nop, add57, v, prev;
  initial begin
    nop = mk("nop", 6'h3f, 6'h00, 0, 0, 0, 0, 0);
    add57 = mk("add57", 6'h00, 6'h20, 5, 7, 0, 0, 12);
    tab.push_back(mk("addu_wrap", 6'h00, 6'h21, 32'hffffffff, 1, 0, 0, 0));
    tab.push_back(mk("sub_neg", 6'h00, 6'h22, 3, 5, 0, 0, 32'hfffffffe));
    tab.push_back(mk("addi_neg", 6'h08, 6'h00, 32'h10, 0, 16'hfffc, 0, 32'h0c));
    tab.push_back(mk("lw_addr", 6'h23, 6'h3f, 32'h100, 0, 16'h0008, 0, 32'h108));
    tab.push_back(mk("slt", 6'h00, 6'h2a, 32'hffffffff, 1, 0, 0, 1));
    tab.push_back(mk("sltu", 6'h00, 6'h2b, 32'hffffffff, 1, 0, 0, 0));
    tab.push_back(mk("sltiu", 6'h0b, 6'h00, 1, 0, 16'hffff, 0, 1));
    tab.push_back(mk("sra", 6'h00, 6'h03, 0, 32'h80000000, 0, 4, 32'hf8000000));
    tab.push_back(mk("srlv", 6'h00, 6'h06, 32'h24, 32'hf0, 0, 0, 32'h0f));
    tab.push_back(mk("lui", 6'h0f, 6'h00, 32'hdeadbeef, 0, 16'h1234, 0, 32'h12340000));
    tab.push_back(mk("ori", 6'h0d, 6'h00, 0, 0, 16'h8000, 0, 32'h00008000));
    tab.push_back(mk("b2b_add", 6'h00, 6'h20, 2, 3, 0, 0, 5));
    tab.push_back(mk("b2b_sub", 6'h00, 6'h22, 10, 4, 0, 0, 6));
    tab.push_back(mk("b2b_beq", 6'h04, 6'h20, 1, 1, 16'h0004, 0, 0));
    tab.push_back(mk("b2b_xor", 6'h00, 6'h26, 32'hff00, 32'h0f0f, 0, 0, 32'hf00f));
    tab.push_back(mk("sll0", 6'h00, 6'h00, 9, 32'h1234, 0, 0, 32'h1234));
    tab.push_back(mk("jr", 6'h00, 6'h08, 5, 6, 0, 0, 0));
    tab.push_back(mk("nor", 6'h00, 6'h27, 0, 0, 0, 0, 32'hffffffff));
    tab.push_back(mk("srav", 6'h00, 6'h07, 32'h1f, 32'h80000000, 0, 0, 32'hffffffff));
    tab.push_back(mk("sllv", 6'h00, 6'h04, 32'h21, 1, 0, 0, 2));
    tab.push_back(mk("xori", 6'h0e, 6'h00, 32'hffff0000, 0, 16'h8001, 0, 32'hffff8001));
    tab.push_back(mk("j", 6'h02, 6'h20, 3, 3, 16'h1111, 0, 0));
    rst = 0;
    drive(add57, add57);
    drive(add57, add57);
    check("reset_hold", 0);
    rst = 1;
    drive(add57, add57);
    check("release_nop", 0);
    drive(add57, nop);
    check("release_add", 12);
    for (int i = 0; i <= tab.size(); i++) begin
      drive(i == 0 ? nop : tab[i-1], i < tab.size() ? tab[i] : nop);
      if (i > 0) check(tab[i-1].name, tab[i-1].exp);
    end
    v = mk("add23", 6'h00, 6'h20, 2, 3, 0, 0, 5);
    drive(nop, v);
    rst = 0;
    drive(v, v);
    check("mid_reset", 0);
    rst = 1;
    drive(v, v);
    check("post_reset_nop", 0);
    drive(v, nop);
    check("post_reset_add", 5);
    v = mk("addi1", 6'h08, 6'h00, 0, 0, 16'h0001, 0, 0);
    drive(nop, v);
    for (int i = 1; i <= 5; i++) begin
      v.a = bus.rslt;
      drive(v, i < 5 ? v : nop);
      check("feedback", i);
    end
    prev = nop;
    for (int i = 0; i < 400; i++) begin
      logic [5:0] ops[16];
      logic [5:0] fns[20];
      ops = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
              6'h23, 6'h2b, 6'h04, 6'h3f};
      fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b,
              6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h01, 6'h3c};
      v.name = "random";
      v.op = ops[$urandom_range(0, 15)];
      if ($urandom_range(0, 15) == 0) v.op = 6'($urandom);
      v.fn = fns[$urandom_range(0, 19)];
      v.a = ($urandom_range(0, 3) == 0) ? 32'h80000000 | 32'($urandom_range(0, 3)) : $urandom;
      v.b = ($urandom_range(0, 3) == 0) ? 32'hffffffff - 32'($urandom_range(0, 3)) : $urandom;
      v.imm = 16'($urandom);
      v.sh = 5'($urandom);
      drive(prev, v);
      if (i > 0) check("random", model(prev));
      prev = v;
    end
    drive(prev, nop);
    check("random_last", model(prev));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
